// File: rtl/edge_rnm_pkg.sv
// Shared types and default analog constants for the RNM edge detector / reconstructor pair.
package edge_rnm_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } edge_state_t;

  localparam real DEFAULT_THRESH    = 0.5;
  localparam real DEFAULT_AMPLITUDE = 1.0;

endpackage

// File: rtl/edge_event_sampler.sv
// Thresholds one wreal pulse stream and flags a 0->1 transition against the previous clock's sample.
module edge_event_sampler
  import edge_rnm_pkg::*;
#(
  parameter real THRESH = DEFAULT_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  real  pulse_i,
  output logic evt_o
);

  logic sample;
  logic prev_q;

  assign sample = (pulse_i > THRESH);
  assign evt_o  = sample & ~prev_q;

  // Tracks the sample even while the reconstructor ignores events, so a held pulse never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sample;
    end
  end

endmodule

// File: rtl/edge_to_level_rnm.sv
// Rebuilds a wreal level from rising/falling edge-pulse streams using a linear slew ramp.
module edge_to_level_rnm
  import edge_rnm_pkg::*;
#(
  parameter real AMPLITUDE   = DEFAULT_AMPLITUDE,
  parameter real THRESH      = DEFAULT_THRESH,
  parameter int  RAMP_CYCLES = 4,
  parameter int  CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              rising_edge,
  input  real              falling_edge,
  output real              a_out,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int KW = (RAMP_CYCLES < 2) ? 1 : $clog2(RAMP_CYCLES + 1);
  localparam logic [KW-1:0] KMAX = KW'(RAMP_CYCLES);

  logic r_evt;
  logic f_evt;

  edge_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic          accept_evt;
  logic          error_evt;
  int            k_up;
  int            k_dn;
  edge_state_t   rise_state;
  edge_state_t   fall_state;
  logic [KW-1:0] rise_k;
  logic [KW-1:0] fall_k;

  edge_event_sampler #(.THRESH(THRESH)) u_rise_sampler (
    .clk     (clk),
    .rst     (rst),
    .pulse_i (rising_edge),
    .evt_o   (r_evt)
  );

  edge_event_sampler #(.THRESH(THRESH)) u_fall_sampler (
    .clk     (clk),
    .rst     (rst),
    .pulse_i (falling_edge),
    .evt_o   (f_evt)
  );

  // One step up or down from the current k; reversals and fresh edges both step on the same clock.
  always_comb begin
    k_up       = int'(k_q) + 1;
    k_dn       = int'(k_q) - 1;
    rise_state = (k_up >= RAMP_CYCLES) ? HIGH : RISE;
    rise_k     = (k_up >= RAMP_CYCLES) ? KMAX : KW'(k_up);
    fall_state = (k_dn <= 0) ? LOW : FALL;
    fall_k     = (k_dn <= 0) ? '0 : KW'(k_dn);
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    accept_evt = 1'b0;
    error_evt  = 1'b0;

    case (state_q)
      RISE: begin
        state_d = rise_state;
        k_d     = rise_k;
      end
      FALL: begin
        state_d = fall_state;
        k_d     = fall_k;
      end
      default: ;
    endcase

    if (en) begin
      if (r_evt && f_evt) begin
        error_evt = 1'b1;
      end else if (r_evt) begin
        if (state_q == LOW || state_q == FALL) begin
          state_d    = rise_state;
          k_d        = rise_k;
          accept_evt = 1'b1;
        end else begin
          error_evt = 1'b1;
        end
      end else if (f_evt) begin
        if (state_q == HIGH || state_q == RISE) begin
          state_d    = fall_state;
          k_d        = fall_k;
          accept_evt = 1'b1;
        end else begin
          error_evt = 1'b1;
        end
      end
    end

    edge_cnt_d = edge_cnt_q;
    if (accept_evt && edge_cnt_q != '1) edge_cnt_d = edge_cnt_q + 1'b1;
    err_cnt_d = err_cnt_q;
    if (error_evt && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOW;
      k_q        <= '0;
      edge_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      edge_cnt_q <= edge_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign level      = (state_q == RISE) || (state_q == HIGH);
  assign busy       = (state_q == RISE) || (state_q == FALL);
  assign edge_count = edge_cnt_q;
  assign err_count  = err_cnt_q;

  // The level is recomputed from k every cycle so no rounding error builds up.
  generate
    if (RAMP_CYCLES == 0) begin : g_step
      always_comb a_out = level ? AMPLITUDE : 0.0;
    end else begin : g_ramp
      always_comb a_out = AMPLITUDE * real'(int'(k_q)) / real'(RAMP_CYCLES);
    end
  endgenerate

endmodule

// File: tb/tb_edge_to_level_rnm.sv
// Directed-vector bench for edge_to_level_rnm with AMPLITUDE=1.0 and RAMP_CYCLES=4.
module tb_edge_to_level_rnm;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  real              rising_edge;
  real              falling_edge;
  real              a_out;
  logic             level;
  logic             busy;
  logic [CNT_W-1:0] edge_count;
  logic [CNT_W-1:0] err_count;

  int total;
  int bad;

  edge_to_level_rnm #(
    .AMPLITUDE   (1.0),
    .THRESH      (0.5),
    .RAMP_CYCLES (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .a_out        (a_out),
    .level        (level),
    .busy         (busy),
    .edge_count   (edge_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input real observed, input real expected);
    total++;
    if ((observed - expected) > 1.0e-6 || (expected - observed) > 1.0e-6) begin
      bad++;
      $display("[TB] FAIL %s: got %f, want %f", tag, observed, expected);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then stop at the next falling edge.
  task automatic applyStimulus(input real r, input real f, input logic e);
    rising_edge  = r;
    falling_edge = f;
    en           = e;
    @(negedge clk);
  endtask

  task automatic checkState(input string tag, input real a, input int lvl, input int bsy,
                            input int edges, input int errs);
    checkOutput({tag, ".a_out"}, a_out, a);
    checkOutput({tag, ".level"}, real'(int'(level)), real'(lvl));
    checkOutput({tag, ".busy"}, real'(int'(busy)), real'(bsy));
    checkOutput({tag, ".edges"}, real'(int'(edge_count)), real'(edges));
    checkOutput({tag, ".errs"}, real'(int'(err_count)), real'(errs));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    en           = 1'b1;
    rising_edge  = 0.0;
    falling_edge = 0.0;
    repeat (2) @(negedge clk);
    checkState("reset", 0.0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("idle", 0.0, 0, 0, 0, 0);

    // basic rise
    applyStimulus(1.0, 0.0, 1'b1);
    checkState("rise1", 0.25, 1, 1, 1, 0);
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("rise2", 0.50, 1, 1, 1, 0);
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("rise3", 0.75, 1, 1, 1, 0);
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("rise4", 1.00, 1, 0, 1, 0);

    // fall from HIGH
    applyStimulus(0.0, 1.0, 1'b1);
    checkState("fall1", 0.75, 0, 1, 2, 0);
    applyStimulus(0.0, 0.0, 1'b1);
    checkOutput("fall2.a_out", a_out, 0.50);
    applyStimulus(0.0, 0.0, 1'b1);
    checkOutput("fall3.a_out", a_out, 0.25);
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("fall4", 0.0, 0, 0, 2, 0);

    // reversal mid-rise
    applyStimulus(1.0, 0.0, 1'b1);
    checkOutput("rev.up1", a_out, 0.25);
    applyStimulus(0.0, 0.0, 1'b1);
    checkOutput("rev.up2", a_out, 0.50);
    applyStimulus(0.0, 1.0, 1'b1);
    checkState("rev.dn1", 0.25, 0, 1, 4, 0);
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("rev.dn2", 0.0, 0, 0, 4, 0);

    // redundant rise while HIGH
    applyStimulus(1.0, 0.0, 1'b1);
    repeat (3) applyStimulus(0.0, 0.0, 1'b1);
    checkState("toHigh", 1.0, 1, 0, 5, 0);
    applyStimulus(1.0, 0.0, 1'b1);
    checkState("redund", 1.0, 1, 0, 5, 1);
    applyStimulus(0.0, 1.0, 1'b1);
    repeat (3) applyStimulus(0.0, 0.0, 1'b1);
    checkState("toLow", 0.0, 0, 0, 6, 1);

    // simultaneous rise and fall in LOW
    applyStimulus(1.0, 1.0, 1'b1);
    checkState("both", 0.0, 0, 0, 6, 2);
    applyStimulus(0.0, 0.0, 1'b1);

    // held rise pulse gives a single event
    applyStimulus(1.0, 0.0, 1'b1);
    applyStimulus(1.0, 0.0, 1'b1);
    applyStimulus(1.0, 0.0, 1'b1);
    applyStimulus(1.0, 0.0, 1'b1);
    checkOutput("held4.a_out", a_out, 1.0);
    applyStimulus(1.0, 0.0, 1'b1);
    checkState("held5", 1.0, 1, 0, 7, 2);
    applyStimulus(0.0, 1.0, 1'b1);
    repeat (3) applyStimulus(0.0, 0.0, 1'b1);
    checkState("heldDn", 0.0, 0, 0, 8, 2);

    // enable gating
    applyStimulus(1.0, 0.0, 1'b0);
    checkState("enOff", 0.0, 0, 0, 8, 2);
    applyStimulus(0.0, 0.0, 1'b1);
    applyStimulus(1.0, 0.0, 1'b0);
    applyStimulus(1.0, 0.0, 1'b1);
    checkState("enRiseHeld", 0.0, 0, 0, 8, 2);
    applyStimulus(0.0, 0.0, 1'b1);

    // asynchronous reset mid-ramp
    applyStimulus(1.0, 0.0, 1'b1);
    applyStimulus(0.0, 0.0, 1'b1);
    checkOutput("preRst.a_out", a_out, 0.50);
    #2 rst = 1'b1;
    #1;
    checkState("asyncRst", 0.0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0.0, 0.0, 1'b1);
    checkState("postRst", 0.0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
